// File: rtl/dma_bus_arbiter_if.sv
// Bus bundle between the CRTC row-fetch DMA, the Z80 bus handshake and the
// shared memory port. The arbiter sits on the slave side; the environment
// (CRTC, Z80 and memory together) sits on the master side.
interface dma_bus_arbiter_if;
    logic        dma_busreq;
    logic        dma_busack;
    logic [16:0] dma_adr;
    logic [7:0]  dma_data;
    logic        cpu_busrq_n;
    logic        cpu_busak_n;
    logic [16:0] cpu_adr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic [7:0]  cpu_rdata;
    logic [16:0] mem_adr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic        dma_active;
    logic        timeout_err;
    logic        err_clr;

    modport slave (
        input  dma_busreq, dma_adr, cpu_busak_n, cpu_adr, cpu_wdata, cpu_we,
               mem_rdata, err_clr,
        output dma_busack, dma_data, cpu_busrq_n, cpu_rdata, mem_adr,
               mem_wdata, mem_we, dma_active, timeout_err
    );

    modport master (
        output dma_busreq, dma_adr, cpu_busak_n, cpu_adr, cpu_wdata, cpu_we,
               mem_rdata, err_clr,
        input  dma_busack, dma_data, cpu_busrq_n, cpu_rdata, mem_adr,
               mem_wdata, mem_we, dma_active, timeout_err
    );
endinterface

// File: rtl/dma_bus_arbiter.sv
// Responder side of the CRTC row-fetch DMA. Takes the Z80 bus with
// BUSRQ/BUSAK, hands the memory port to the CRTC while granted, then gives
// the bus back and enforces a minimum CPU-owned gap before the next grant.
// All handshake outputs decode the registered state, so an asynchronous
// reset returns the bus to the CPU without waiting for a clock edge.
module dma_bus_arbiter #(
    parameter int TIMEOUT = 4095,
    parameter int CPU_GAP = 4
) (
    input  logic               clk,
    input  logic               reset,
    dma_bus_arbiter_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        GRANT,
        RELEASE,
        GAP
    } state_e;

    // Last counter value before the limit is reached on the next edge.
    localparam logic [11:0] WAIT_LAST = 12'(TIMEOUT - 1);
    localparam logic [11:0] GAP_LAST  = 12'(CPU_GAP - 1);

    state_e      r_state;
    state_e      w_nextState;
    logic [11:0] r_waitCnt;
    logic [11:0] r_gapCnt;
    logic        r_timeoutErr;
    logic        w_timeout;

    // State register; reset parks the arbiter in IDLE with the CPU owning the bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decision plus the memory mux and handshake outputs.
    always_comb begin
        w_nextState     = r_state;
        w_timeout       = 1'b0;
        bus.cpu_busrq_n = 1'b1;
        bus.dma_busack  = 1'b0;
        bus.dma_active  = 1'b0;
        bus.mem_adr     = bus.cpu_adr;
        bus.mem_wdata   = bus.cpu_wdata;
        bus.mem_we      = bus.cpu_we;
        bus.cpu_rdata   = bus.mem_rdata;
        bus.dma_data    = bus.mem_rdata;
        bus.timeout_err = r_timeoutErr;

        case (r_state)
            IDLE: begin
                if (bus.dma_busreq) begin
                    w_nextState = REQ;
                end
            end
            REQ: begin
                bus.cpu_busrq_n = 1'b0;
                if (!bus.dma_busreq) begin
                    w_nextState = RELEASE;
                end else if (!bus.cpu_busak_n) begin
                    w_nextState = GRANT;
                end else if (r_waitCnt >= WAIT_LAST) begin
                    w_timeout   = 1'b1;
                    w_nextState = RELEASE;
                end
            end
            GRANT: begin
                bus.cpu_busrq_n = 1'b0;
                bus.dma_busack  = 1'b1;
                bus.dma_active  = 1'b1;
                bus.mem_adr     = bus.dma_adr;
                bus.mem_we      = 1'b0;
                bus.cpu_rdata   = 8'h00;
                if (!bus.dma_busreq) begin
                    w_nextState = RELEASE;
                end
            end
            RELEASE: begin
                bus.mem_adr   = bus.dma_adr;
                bus.mem_we    = 1'b0;
                bus.cpu_rdata = 8'h00;
                if (bus.cpu_busak_n) begin
                    w_nextState = GAP;
                end
            end
            GAP: begin
                if (r_gapCnt >= GAP_LAST) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Wait and gap counters: zero outside their state, saturate instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_waitCnt <= '0;
            r_gapCnt  <= '0;
        end else begin
            if (r_state == REQ && w_nextState == REQ) begin
                if (r_waitCnt != '1) begin
                    r_waitCnt <= r_waitCnt + 12'd1;
                end
            end else begin
                r_waitCnt <= '0;
            end
            if (r_state == GAP && w_nextState == GAP) begin
                if (r_gapCnt != '1) begin
                    r_gapCnt <= r_gapCnt + 12'd1;
                end
            end else begin
                r_gapCnt <= '0;
            end
        end
    end

    // Sticky timeout flag; a new timeout takes precedence over a clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timeoutErr <= 1'b0;
        end else if (w_timeout) begin
            r_timeoutErr <= 1'b1;
        end else if (bus.err_clr) begin
            r_timeoutErr <= 1'b0;
        end
    end

endmodule

// File: doc/dma_bus_arbiter.md
DMA_BUS_ARBITER -- requirements
Module: dma_bus_arbiter

Purpose: responder side of the CRTC row-fetch DMA. It accepts the CRTC bus request, takes the Z80 bus via BUSRQ/BUSAK, grants the bus to the CRTC, and returns the bus to the CPU afterwards.

Interface
REQ-001 Parameter TIMEOUT, default 4095: maximum cycles spent in REQ waiting for cpu_busak_n.
REQ-002 Parameter CPU_GAP, default 4: minimum CPU-owned cycles between two grants.
REQ-003 Reset and clocking: one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  system clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 dma_busreq  in  1  CRTC bus request, level, held until the CRTC is done.
REQ-007 dma_busack  out  1  grant to the CRTC.
REQ-008 dma_adr  in  17  CRTC read address.
REQ-009 dma_data  out  8  read data returned to the CRTC.
REQ-010 cpu_busrq_n  out  1  Z80 BUSRQ, active-low.
REQ-011 cpu_busak_n  in  1  Z80 BUSAK, active-low, synchronous to clk.
REQ-012 cpu_adr  in  17  CPU memory address.
REQ-013 cpu_wdata  in  8  CPU write data.
REQ-014 cpu_we  in  1  CPU write strobe.
REQ-015 cpu_rdata  out  8  read data returned to the CPU.
REQ-016 mem_adr  out  17  memory address.
REQ-017 mem_wdata  out  8  memory write data.
REQ-018 mem_we  out  1  memory write enable.
REQ-019 mem_rdata  in  8  memory read data.
REQ-020 dma_active  out  1  high while the DMA owns memory.
REQ-021 timeout_err  out  1  sticky timeout flag.
REQ-022 err_clr  in  1  clears timeout_err.

Function
REQ-023 FSM states SHALL be IDLE, REQ, GRANT, RELEASE, GAP.
REQ-024 IDLE->REQ when dma_busreq=1; cpu_busrq_n SHALL be registered low from the next cycle.
REQ-025 REQ->GRANT when cpu_busak_n=0 and dma_busreq=1.
REQ-026 REQ->RELEASE without a grant when dma_busreq=0, including when it falls in the same cycle cpu_busak_n goes low.
REQ-027 REQ timeout: a 12-bit wait counter clears on REQ entry and increments each REQ cycle.
REQ-028 When the wait counter reaches TIMEOUT while cpu_busak_n=1, the FSM SHALL set timeout_err and go to RELEASE.
REQ-029 In GRANT, dma_busack=1 (registered, first high in the cycle after BUSAK is seen), dma_active=1, mem_adr=dma_adr, mem_we=0, mem_wdata=cpu_wdata.
REQ-030 dma_data SHALL be mem_rdata passed through combinationally (zero added latency) in all states; the memory's own read latency applies.
REQ-031 GRANT->RELEASE when dma_busreq=0; dma_busack SHALL drop in the same cycle as the transition.
REQ-032 In RELEASE, cpu_busrq_n=1 and the mux SHALL stay on the DMA side with mem_we=0.
REQ-033 RELEASE->GAP when cpu_busak_n=1.
REQ-034 In GAP, the mux SHALL select the CPU; the FSM counts CPU_GAP cycles, then goes to IDLE, even if dma_busreq is already high.
REQ-035 In IDLE, REQ and GAP: mem_adr=cpu_adr, mem_wdata=cpu_wdata, mem_we=cpu_we, cpu_rdata=mem_rdata.
REQ-036 In GRANT and RELEASE, cpu_rdata SHALL hold 8'h00 and cpu_we SHALL be ignored.
REQ-037 cpu_busrq_n SHALL be low exactly in REQ and GRANT.
REQ-038 err_clr=1 SHALL clear timeout_err.
REQ-039 A timeout in the same cycle as err_clr SHALL leave timeout_err set (set wins).
REQ-040 Wait and gap counters SHALL NOT wrap; both reload on state entry.

Reset
REQ-041 Asserting reset at any time, including mid-GRANT, SHALL force IDLE and the following reset values: cpu_busrq_n=1, dma_busack=0, dma_active=0, timeout_err=0, counters=0.
REQ-042 During reset the mux SHALL select the CPU side with mem_we following cpu_we.
REQ-043 After reset release, a dma_busreq already high SHALL be honoured from IDLE on the first clock edge.

Verification
REQ-044 Normal grant: dma_busreq=1; cpu_busak_n goes low 3 cycles after cpu_busrq_n goes low -> dma_busack=1 one cycle later; mem_adr follows dma_adr=0x0F300; mem_we=0 even with cpu_we=1.
REQ-045 Release and gap: drop dma_busreq in GRANT, then raise cpu_busak_n after 2 cycles -> dma_busack=0 immediately; CPU mux restored on the GAP cycle; no new REQ for 4 cycles although dma_busreq is re-asserted.
REQ-046 Timeout: cpu_busak_n held high, TIMEOUT=15 -> timeout_err=1 after 15 REQ cycles; dma_busack never asserted; re-request after the gap.
REQ-047 Abort race: dma_busreq falls in the same cycle cpu_busak_n goes low -> no dma_busack pulse; RELEASE->GAP->IDLE.
REQ-048 Reset mid-GRANT -> cpu_busrq_n=1, dma_busack=0, mux on CPU, asynchronously before the next edge.
REQ-049 Clear priority: err_clr=1 coincident with a timeout -> timeout_err=1; err_clr alone one cycle later -> timeout_err=0.
